sr_cmd_debouncer: RTL and testbench

- Upstream command stage for the sr_latch block.
- Takes two raw, bouncy, asynchronous request inputs (set_in, clr_in), then synchronises and debounces them and detects their rising edges.
- Issues clean, mutually exclusive, fixed-width s/r pulses that drive the latch's s and r inputs.
- Simultaneous requests are reported as a conflict, and neither pulse is issued.

---
 rtl/sr_cmd_debouncer.sv | 162 ++++++++++++++++
 tb/tb_sr_cmd_debouncer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_debouncer.sv
// Command front end for sr_latch: synchronises and debounces raw set/clear
// requests and turns their rising edges into exclusive fixed-width s/r pulses.
module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int PULSE_LEN       = 2,
  parameter int PCNT_W          = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    CLR_PULSE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PULSE_LEN - 1);

  // Channel index 0 carries set, index 1 carries clear.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       pend_q, pend_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;

  logic [1:0]       req;
  logic [1:0]       eff;

  always_comb begin
    sync1_d      = {clr_in, set_in};
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    for (int ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (sync2_q[ch] == stable_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_MAX) begin
        stable_d[ch] = sync2_q[ch];
        cnt_d[ch]    = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  assign req = stable_q & ~stable_dly_q;
  assign eff = req | pend_q;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    pend_d     = pend_q;
    s_d        = s_q;
    r_d        = r_q;
    conflict_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (eff[0] && eff[1]) begin
          conflict_d = 1'b1;
          pend_d     = 2'b00;
        end else if (eff[0]) begin
          state_d   = SET_PULSE;
          s_d       = 1'b1;
          pcnt_d    = '0;
          pend_d[0] = 1'b0;
        end else if (eff[1]) begin
          state_d   = CLR_PULSE;
          r_d       = 1'b1;
          pcnt_d    = '0;
          pend_d[1] = 1'b0;
        end
      end
      SET_PULSE: begin
        if (pcnt_q == PCNT_MAX) begin
          s_d     = 1'b0;
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      CLR_PULSE: begin
        if (pcnt_q == PCNT_MAX) begin
          r_d     = 1'b0;
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests arriving mid-command are remembered for the next IDLE cycle.
    if (state_q != IDLE) begin
      pend_d = pend_q | req;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      pend_q       <= '0;
      pcnt_q       <= '0;
      state_q      <= IDLE;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      busy_q       <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      pend_q       <= pend_d;
      pcnt_q       <= pcnt_d;
      state_q      <= state_d;
      s_q          <= s_d;
      r_q          <= r_d;
      busy_q       <= busy_d;
      conflict_q   <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Bench for sr_cmd_debouncer: windowed debounce / pulse-budget model compared
// every cycle, plus directed scenarios with hand-computed edge expectations.
module tb_sr_cmd_debouncer;

  localparam int DEB  = 4;
  localparam int PLEN = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s, r, busy, conflict;

  int checks = 0;
  int errors = 0;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .PULSE_LEN(PLEN),
    .PCNT_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .set_in(set_in),
    .clr_in(clr_in),
    .s(s),
    .r(r),
    .busy(busy),
    .conflict(conflict)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // model: a level changes once the last DEB synchronised samples all
  // disagree with it; a command occupies PLEN pulse cycles plus one gap.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_st [2];
  bit m_st_prev [2];
  bit m_pend [2];
  bit m_win [2][DEB];
  int m_left = 0;
  bit m_kind_set = 1'b0;
  bit m_exp_s = 1'b0, m_exp_r = 1'b0, m_exp_busy = 1'b0, m_exp_conf = 1'b0;
  bit started = 1'b0;

  always @(posedge clk) begin : model
    bit req [2];
    bit in_now [2];
    int diff;
    in_now[0] = set_in;
    in_now[1] = clr_in;
    started = 1'b1;
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_st[ch] = 0; m_st_prev[ch] = 0; m_pend[ch] = 0;
        for (int i = 0; i < DEB; i++) m_win[ch][i] = 0;
      end
      m_left = 0;
      m_exp_s = 0; m_exp_r = 0; m_exp_busy = 0; m_exp_conf = 0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        req[ch] = m_st[ch] && !m_st_prev[ch];
        m_st_prev[ch] = m_st[ch];
        for (int i = DEB - 1; i > 0; i--) m_win[ch][i] = m_win[ch][i-1];
        m_win[ch][0] = m_s2[ch];
        diff = 0;
        for (int i = 0; i < DEB; i++) if (m_win[ch][i] != m_st[ch]) diff++;
        if (diff == DEB) m_st[ch] = !m_st[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = in_now[ch];
      end
      m_exp_conf = 0;
      if (m_left > 0) begin
        m_pend[0] = m_pend[0] | req[0];
        m_pend[1] = m_pend[1] | req[1];
        m_left--;
      end else begin
        if ((req[0] || m_pend[0]) && (req[1] || m_pend[1])) begin
          m_exp_conf = 1;
          m_pend[0] = 0;
          m_pend[1] = 0;
        end else if (req[0] || m_pend[0]) begin
          m_left = PLEN + 1;
          m_kind_set = 1;
          m_pend[0] = 0;
        end else if (req[1] || m_pend[1]) begin
          m_left = PLEN + 1;
          m_kind_set = 0;
          m_pend[1] = 0;
        end
      end
      m_exp_busy = (m_left > 0);
      m_exp_s = m_kind_set && (m_left > 1);
      m_exp_r = !m_kind_set && (m_left > 1);
    end
  end

  // scoreboard compare, every cycle once the first edge has been seen
  always @(negedge clk) begin
    if (started) begin
      chk("model_s", s, m_exp_s);
      chk("model_r", r, m_exp_r);
      chk("model_busy", busy, m_exp_busy);
      chk("model_conflict", conflict, m_exp_conf);
      chk("inv_s_and_r", s & r, 1'b0);
      chk("inv_conflict_while_busy", conflict & busy, 1'b0);
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // directed stimulus; after the k-th negedge we are just past edge k
  initial begin : stim
    logic [31:0] pat;

    // reset held for 5 edges while the inputs toggle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_s", s, 1'b0);
      chk("rst_r", r, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_conflict", conflict, 1'b0);
      set_in = (i % 2 == 0);
      clr_in = (i % 2 != 0);
    end
    set_in = 1'b0;
    clr_in = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("rel_s", s, 1'b0);
    chk("rel_busy", busy, 1'b0);
    settle(10);

    // clean set press
    set_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("set_s", s, (k == 7 || k == 8));
      chk("set_busy", busy, (k >= 7 && k <= 9));
      chk("set_r", r, 1'b0);
      chk("set_conflict", conflict, 1'b0);
    end
    set_in = 1'b0;
    settle(15);

    // short glitch is rejected
    set_in = 1'b1;
    settle(3);
    set_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("glitch_s", s, 1'b0);
      chk("glitch_busy", busy, 1'b0);
    end

    // simultaneous presses
    set_in = 1'b1;
    clr_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("conf_conflict", conflict, (k == 7));
      chk("conf_s", s, 1'b0);
      chk("conf_r", r, 1'b0);
      chk("conf_busy", busy, 1'b0);
    end
    set_in = 1'b0;
    clr_in = 1'b0;
    settle(15);

    // clear queued behind a set
    set_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("queue_s", s, (k == 7 || k == 8));
      chk("queue_r", r, (k == 11 || k == 12));
      chk("queue_busy", busy, (k >= 7 && k <= 9) || (k >= 11 && k <= 13));
      if (k == 2) clr_in = 1'b1;
    end
    set_in = 1'b0;
    clr_in = 1'b0;
    settle(15);

    // reset lands mid pulse
    set_in = 1'b1;
    settle(7);
    chk("midrst_s_before", s, 1'b1);
    reset  = 1'b0;
    set_in = 1'b0;
    @(negedge clk);
    chk("midrst_s", s, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("post_rst_s", s, 1'b0);
      chk("post_rst_r", r, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    // bouncy clear, then a set that arrives while r is in progress
    pat = 32'b1111_1111_1111_1111_1111_1011_1011_0101;
    for (int k = 0; k < 32; k++) begin
      clr_in = pat[k];
      set_in = (k >= 14 && k < 24);
      @(negedge clk);
    end
    clr_in = 1'b0;
    set_in = 1'b0;
    settle(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
